counting_bloom_filter: RTL and testbench
========================================

// Module: counting_bloom_filter
// PURPOSE
//  Parametrised counting Bloom filter: membership set supporting insert, query, delete and clear.
//  Each bucket holds a CNT_W-bit saturating counter instead of a single bit, so deletes are safe.
//  Single-port style datapath updates one hash position per cycle, ready for later SRAM mapping.
//  Sits behind packet-classification logic as a probabilistic pre-filter; valid/ready request side.
// PARAMETERS
//  DATA_W  32    key width in bits; any value >= 1
//  M       1024  bucket count; power of two, >= 2; LOG2M = $clog2(M)
//  K       3     hash functions per key; 1..8
//  CNT_W   4     bucket counter width; >= 2; CMAX = 2**CNT_W-1
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          asynchronous reset, active-high
//  req_valid  in   1          request present
//  req_ready  out  1          block can accept; high only in IDLE
//  req_op     in   2          00 INSERT, 01 QUERY, 10 DELETE, 11 CLEAR
//  req_data   in   DATA_W     key (ignored for CLEAR)
//  rsp_valid  out  1          one-cycle pulse: operation complete
//  rsp_match  out  1          QUERY: all K counters nonzero; 0 for other ops
//  rsp_err    out  1          INSERT clamped at CMAX or DELETE clamped at 0 on any hash step
//  occupancy  out  LOG2M+1    number of buckets with nonzero counter
// BEHAVIOUR
//  Reset: all counters 0, state IDLE, req_ready=1, rsp_valid=rsp_match=rsp_err=0, occupancy=0.
//  Reset mid-operation aborts it; no response is issued; array cleared.
//  Handshake: accept on req_valid&&req_ready at a rising edge; key and op registered on accept.
//  Hash: fold key to 32 bits by XOR of 32-bit chunks (zero-padded top chunk) -> f;
//   SEED_j = 32'h5bd1e995 + j*32'h9e3779b9 (mod 2^32); h_j = (f*SEED_j mod 2^32) >> (32-LOG2M).
//  FSM: IDLE -accept non-CLEAR-> HASH -> PROC (K cycles, j=0..K-1) -> RESP -> IDLE.
//       IDLE -accept CLEAR-> CLR (M cycles, bucket 0..M-1 zeroed) -> RESP -> IDLE.
//  HASH: all K indices registered. PROC step j acts on bucket h_j only:
//   INSERT: cnt = (cnt==CMAX) ? CMAX (err) : cnt+1; DELETE: cnt = (cnt==0) ? 0 (err) : cnt-1;
//   QUERY: match cleared if cnt==0; counters untouched.
//  Duplicate indices (h_a==h_b) are stepped once per occurrence; INSERT then DELETE of a key is exact.
//  occupancy +1 on 0->1 transition, -1 on 1->0 transition; CLR sets it to 0 on completion.
//  RESP: rsp_valid=1 for one cycle with rsp_match/rsp_err; both 0 outside RESP. req_ready=0.
//  Latency: rsp_valid high K+1 edges after accepting edge (ops), M edges (CLEAR). No rsp backpressure.
//  Throughput: one op per K+3 cycles; req_valid during busy is held off, not dropped.
// CONFIGURATION
//  CBF_STATS_EN defined: adds outputs stat_ins, stat_qry, stat_hit (32 bits each, saturating at
//   2^32-1), incremented in RESP for INSERT, QUERY, QUERY with match=1; zeroed by rst and CLEAR.
//  CBF_STATS_EN undefined: those ports and counters do not exist; all other behaviour identical.
// TESTING (K=3, M=1024, CNT_W=4, DATA_W=32)
//  rst, QUERY 0xDEADBEEF -> rsp_valid 4 edges after accept, rsp_match=0, rsp_err=0, occupancy=0.
//  INSERT 0xDEADBEEF, QUERY 0xDEADBEEF -> rsp_match=1; occupancy = count of distinct h_j (1..3).
//  INSERT key x2, DELETE x1, QUERY -> match=1; DELETE again, QUERY -> match=0, occupancy=0.
//  INSERT same key 16 times -> rsp_err=0 on #1..#15, 1 on #16; DELETE unseen key on empty -> err=1.
//  INSERT 5 keys, CLEAR -> rsp_valid 1024 edges later, req_ready=0 throughout; occupancy=0; QUERY misses.
//  rst pulse during PROC of INSERT -> no rsp_valid, req_ready=1 next cycle, QUERY of key -> match=0.

Source files
------------

// File: rtl/counting_bloom_filter.sv
// Counting Bloom filter: K hashed buckets of CNT_W-bit saturating counters, one bucket update per cycle.
// Optional statistics outputs (stat_ins/stat_qry/stat_hit) are enabled by defining CBF_STATS_EN.
module counting_bloom_filter #(
  parameter int DATA_W = 32,
  parameter int M      = 1024,
  parameter int K      = 3,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DATA_W-1:0]     req_data,
  output logic                  rsp_valid,
  output logic                  rsp_match,
  output logic                  rsp_err,
`ifdef CBF_STATS_EN
  output logic [31:0]           stat_ins,
  output logic [31:0]           stat_qry,
  output logic [31:0]           stat_hit,
`endif
  output logic [$clog2(M):0]    occupancy
);
  localparam int LOG2M = $clog2(M);
  localparam int NCH   = (DATA_W + 31) / 32;
  localparam int SW    = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] CMAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [LOG2M:0]   OCC_ONE = (LOG2M + 1)'(1);
  localparam logic [1:0] OP_INS = 2'b00, OP_QRY = 2'b01, OP_DEL = 2'b10, OP_CLR = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_HASH, S_PROC, S_CLR, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_W-1:0]     key_q, key_d;
  logic [LOG2M-1:0]      idx_q [K];
  logic [SW-1:0]         step_q, step_d;
  logic [LOG2M-1:0]      clr_q, clr_d;
  logic                  match_q, match_d, err_q, err_d;
  logic [LOG2M:0]        occ_q, occ_d;
  logic                  req_ready_q, rsp_valid_q, rsp_match_q, rsp_err_q;
  logic [CNT_W-1:0]      cnt_q [M];
  logic                  wr_en, idx_load;
  logic [LOG2M-1:0]      wr_addr;
  logic [CNT_W-1:0]      wr_data, cur;
`ifdef CBF_STATS_EN
  logic [31:0]           stat_ins_q, stat_qry_q, stat_hit_q;
`endif

  // Fold key to 32 bits, multiply by the per-function seed, keep the top LOG2M bits.
  function automatic logic [LOG2M-1:0] hash_idx(input logic [DATA_W-1:0] key, input int j);
    logic [NCH*32-1:0] pad;
    logic [31:0] f, seed, prod;
    pad = '0;
    pad[DATA_W-1:0] = key;
    f = 32'h0;
    for (int c = 0; c < NCH; c++) f = f ^ pad[c*32 +: 32];
    seed = 32'h5bd1e995 + 32'(j) * 32'h9e3779b9;
    prod = f * seed;
    return prod[31 -: LOG2M];
  endfunction

  // Next-state, single write port and per-step bookkeeping.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    key_d    = key_q;
    step_d   = step_q;
    clr_d    = clr_q;
    match_d  = match_q;
    err_d    = err_q;
    occ_d    = occ_q;
    idx_load = 1'b0;
    cur      = cnt_q[idx_q[step_q]];
    wr_en    = 1'b0;
    wr_addr  = idx_q[step_q];
    wr_data  = cur;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          key_d = req_data;
          err_d = 1'b0;
          if (req_op == OP_CLR) begin
            clr_d   = '0;
            state_d = S_CLR;
          end else begin
            state_d = S_HASH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HASH: begin
        idx_load = 1'b1;
        step_d   = '0;
        match_d  = 1'b1;
        err_d    = 1'b0;
        state_d  = S_PROC;
      end
      S_PROC: begin
        case (op_q)
          OP_INS: begin
            if (cur == CMAX) begin
              err_d = 1'b1;
            end else begin
              wr_en   = 1'b1;
              wr_data = cur + CNT_ONE;
              if (cur == '0) occ_d = occ_q + OCC_ONE;
              else           occ_d = occ_q;
            end
          end
          OP_DEL: begin
            if (cur == '0) begin
              err_d = 1'b1;
            end else begin
              wr_en   = 1'b1;
              wr_data = cur - CNT_ONE;
              if (cur == CNT_ONE) occ_d = occ_q - OCC_ONE;
              else                occ_d = occ_q;
            end
          end
          OP_QRY: begin
            if (cur == '0) match_d = 1'b0;
            else           match_d = match_q;
          end
          default: ;
        endcase
        if (step_q == SW'(K - 1)) state_d = S_RESP;
        else                      step_d  = step_q + SW'(1);
      end
      S_CLR: begin
        wr_en   = 1'b1;
        wr_addr = clr_q;
        wr_data = '0;
        if (clr_q == LOG2M'(M - 1)) begin
          occ_d   = '0;
          state_d = S_RESP;
        end else begin
          clr_d = clr_q + LOG2M'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and registered handshake/response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_INS;
      key_q       <= '0;
      step_q      <= '0;
      clr_q       <= '0;
      match_q     <= 1'b0;
      err_q       <= 1'b0;
      occ_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_match_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      for (int j = 0; j < K; j++) idx_q[j] <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      key_q       <= key_d;
      step_q      <= step_d;
      clr_q       <= clr_d;
      match_q     <= match_d;
      err_q       <= err_d;
      occ_q       <= occ_d;
      req_ready_q <= (state_d == S_IDLE);
      rsp_valid_q <= (state_d == S_RESP);
      rsp_match_q <= (state_d == S_RESP) && (op_q == OP_QRY) && match_d;
      rsp_err_q   <= (state_d == S_RESP) && (op_q != OP_CLR) && err_d;
      if (idx_load) begin
        for (int j = 0; j < K; j++) idx_q[j] <= hash_idx(key_q, j);
      end
    end
  end

  // Counter array: one write per cycle, whole array cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < M; i++) cnt_q[i] <= '0;
    end else if (wr_en) begin
      cnt_q[wr_addr] <= wr_data;
    end
  end

`ifdef CBF_STATS_EN
  // Saturating operation counters, bumped while the response is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ins_q <= 32'h0;
      stat_qry_q <= 32'h0;
      stat_hit_q <= 32'h0;
    end else if (state_q == S_RESP) begin
      if (op_q == OP_CLR) begin
        stat_ins_q <= 32'h0;
        stat_qry_q <= 32'h0;
        stat_hit_q <= 32'h0;
      end else begin
        if (op_q == OP_INS && stat_ins_q != 32'hFFFF_FFFF) stat_ins_q <= stat_ins_q + 32'h1;
        if (op_q == OP_QRY && stat_qry_q != 32'hFFFF_FFFF) stat_qry_q <= stat_qry_q + 32'h1;
        if (rsp_match_q && stat_hit_q != 32'hFFFF_FFFF)     stat_hit_q <= stat_hit_q + 32'h1;
      end
    end
  end

  assign stat_ins = stat_ins_q;
  assign stat_qry = stat_qry_q;
  assign stat_hit = stat_hit_q;
`endif

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_match = rsp_match_q;
  assign rsp_err   = rsp_err_q;
  assign occupancy = occ_q;
endmodule

// File: tb/tb_counting_bloom_filter.sv
// Scoreboard bench for counting_bloom_filter: stimulus pushes model results, a negedge monitor compares.
module tb_counting_bloom_filter;
  localparam int DATA_W = 32, M = 1024, K = 3, CNT_W = 4, LOG2M = 10;
  localparam int CMAX = 15;

  logic              clk = 1'b0, rst = 1'b1, req_valid = 1'b0;
  logic [1:0]        req_op = 2'b00;
  logic [DATA_W-1:0] req_data = '0;
  logic              req_ready, rsp_valid, rsp_match, rsp_err;
  logic [LOG2M:0]    occupancy;

  counting_bloom_filter #(.DATA_W(DATA_W), .M(M), .K(K), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_match(rsp_match), .rsp_err(rsp_err),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct { bit match; bit err; int occ; int lat; int acc; } exp_t;
  exp_t sbq[$];
  int   cnt_m [M];
  int   total = 0, passed = 0, cyc = 0;
  bit   idle_bad = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, longint act, longint expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Reference hash with 64-bit arithmetic and explicit modulo 2^32.
  function automatic int href(bit [31:0] key, int j);
    longint unsigned seed, p;
    seed = (64'h5bd1e995 + 64'(j) * 64'h9e3779b9) % 64'h1_0000_0000;
    p    = ({32'h0, key} * seed) % 64'h1_0000_0000;
    return int'(p >> (32 - LOG2M));
  endfunction

  function automatic exp_t model_op(bit [1:0] op, bit [31:0] key);
    exp_t e;
    int   idx;
    e.match = (op == 2'b01);
    e.err   = 1'b0;
    e.acc   = 0;
    if (op == 2'b11) begin
      foreach (cnt_m[i]) cnt_m[i] = 0;
      e.lat = M;
    end else begin
      e.lat = K + 1;
      for (int j = 0; j < K; j++) begin
        idx = href(key, j);
        if (op == 2'b00) begin
          if (cnt_m[idx] == CMAX) e.err = 1'b1; else cnt_m[idx]++;
        end else if (op == 2'b10) begin
          if (cnt_m[idx] == 0) e.err = 1'b1; else cnt_m[idx]--;
        end else if (cnt_m[idx] == 0) begin
          e.match = 1'b0;
        end
      end
    end
    e.occ = 0;
    foreach (cnt_m[i]) if (cnt_m[i] != 0) e.occ++;
    return e;
  endfunction

  // Monitor: pop one expectation per response pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (!rsp_valid && (rsp_match || rsp_err)) idle_bad = 1'b1;
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rsp_match", rsp_match, e.match);
          chk("rsp_err", rsp_err, e.err);
          chk("occupancy", occupancy, e.occ);
          chk("latency", cyc - e.acc - 1, e.lat);
        end
      end
    end
  end

  task automatic wait_ready();
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) chk("ready_timeout", 1, 0);
  endtask

  task automatic do_op(bit [1:0] op, bit [31:0] key);
    exp_t e;
    bit   ready_bad = 1'b0;
    int   w = 0;
    wait_ready();
    req_valid = 1'b1;
    req_op    = op;
    req_data  = key;
    e         = model_op(op, key);
    e.acc     = cyc;
    sbq.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    forever begin
      #1;
      if (req_ready !== 1'b0) ready_bad = 1'b1;
      if (sbq.size() == 0) break;
      if (w >= 1500) begin
        chk("rsp_timeout", 1, 0);
        sbq.delete();
        break;
      end
      @(negedge clk);
      w++;
    end
    chk("ready_low_busy", ready_bad, 0);
  endtask

  initial begin
    bit [31:0] pool [6];
    bit [31:0] k5;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] pool [6];
    bit [31:0] key;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_match", rsp_match, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_occupancy", occupancy, 0);

    do_op(2'b01, 32'hDEADBEEF);
    do_op(2'b00, 32'hDEADBEEF);
    do_op(2'b01, 32'hDEADBEEF);

    key = $urandom;
    do_op(2'b00, key);
    do_op(2'b00, key);
    do_op(2'b10, key);
    do_op(2'b01, key);
    do_op(2'b10, key);
    do_op(2'b01, key);

    do_op(2'b11, 32'h0);
    key = $urandom;
    repeat (16) do_op(2'b00, key);
    do_op(2'b11, 32'h0);
    do_op(2'b10, $urandom);

    repeat (5) do_op(2'b00, $urandom);
    do_op(2'b11, 32'h0);
    do_op(2'b01, key);

    foreach (pool[i]) pool[i] = $urandom;
    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 9);
      do_op((r < 4) ? 2'b00 : (r < 7) ? 2'b01 : 2'b10, pool[$urandom_range(0, 5)]);
    end

    // Reset while stepping through an INSERT must abort it silently.
    key = $urandom;
    wait_ready();
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_data  = key;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    foreach (cnt_m[i]) cnt_m[i] = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", req_ready, 1);
    chk("occ_after_rst", occupancy, 0);
    repeat (8) @(negedge clk);
    do_op(2'b01, key);

    chk("idle_flags", idle_bad, 0);
    chk("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
